// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline-boundary register.
// Carries a payload, a destination register address and a control bundle
// through DEPTH slots. Each slot has a valid bit. Supports stall (hold) and
// flush (bubble insertion).
//
// Optional feature: define PIPE_STAGE_REG_STATS_EN to build saturating
// stall and bubble counters. When it is undefined, both counter ports are
// tied to zero.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   stall_i           hold every slot
//   flush_i           invalidate every slot (wins over stall_i)
//   valid_i           input entry is a real instruction
//   data_i/addr_i/ctrl_i  payload, destination address and control in
//   valid_o/data_o/addr_o/ctrl_o  contents of the last slot
//                     (ctrl_o is gated by valid_o)
//   busy_o            OR of all slot valid bits
//   stall_cnt_o       stall-cycle counter
//   bubble_cnt_o      bubble-output counter
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DEPTH  = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              busy_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       bubble_cnt_o
);

  localparam int unsigned CNT_W = 16;

  logic              r_v    [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [CTRL_W-1:0] r_ctrl [DEPTH];
  logic              w_busy;

  // Slot array: reset > flush > stall > shift.
  // A flush leaves the data field alone, because it is don't-care while v=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_v[k]    <= 1'b0;
        r_data[k] <= '0;
        r_addr[k] <= '0;
        r_ctrl[k] <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_v[k]    <= 1'b0;
        r_addr[k] <= '0;
        r_ctrl[k] <= '0;
      end
    end else if (!stall_i) begin
      r_v[0]    <= valid_i;
      r_data[0] <= data_i;
      r_addr[0] <= addr_i;
      // A bubble never carries live control bits into the pipe.
      r_ctrl[0] <= ctrl_i & {CTRL_W{valid_i}};
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_v[k]    <= r_v[k-1];
        r_data[k] <= r_data[k-1];
        r_addr[k] <= r_addr[k-1];
        r_ctrl[k] <= r_ctrl[k-1];
      end
    end
  end

  // Any valid slot means a write is in flight.
  always_comb begin
    w_busy = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_busy = w_busy | r_v[k];
    end
  end

  assign busy_o  = w_busy;
  assign valid_o = r_v[DEPTH-1];
  assign data_o  = r_data[DEPTH-1];
  assign addr_o  = r_addr[DEPTH-1];
  assign ctrl_o  = r_ctrl[DEPTH-1] & {CTRL_W{r_v[DEPTH-1]}};

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating counters. A bubble is counted when an invalid last slot is
  // shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!flush_i) begin
      if (stall_i) begin
        if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else if (!r_v[DEPTH-1]) begin
        if (r_bubble_cnt != {CNT_W{1'b1}}) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`else
  assign stall_cnt_o  = CNT_W'(0);
  assign bubble_cnt_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg.
// Every captured entry goes into a scoreboard queue, tagged with the shift
// edge at which it must appear. An entry is popped and compared when that
// edge is reached.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned DEPTH  = 3;
`ifdef PIPE_STAGE_REG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk, rst, stall_i, flush_i, valid_i;
  logic [DATA_W-1:0] data_i;
  logic [ADDR_W-1:0] addr_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o, busy_o;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W-1:0] addr_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [15:0]       stall_cnt_o, bubble_cnt_o;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .addr_i(addr_i), .ctrl_i(ctrl_i),
    .valid_o(valid_o), .data_o(data_o), .addr_o(addr_o), .ctrl_o(ctrl_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic [CTRL_W-1:0] c;
    int unsigned       emit;
  } ent_t;

  ent_t        sb_q[$];
  ent_t        cur;
  bit          cur_v;
  int unsigned sh;
  logic [15:0] stall_m, bub_m;
  int          n_tests, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("valid_o", 64'(valid_o), 64'(cur_v));
    check_eq("busy_o", 64'(busy_o), 64'(cur_v || sb_q.size() > 0));
    check_eq("ctrl_o", 64'(ctrl_o), cur_v ? 64'(cur.c) : 64'd0);
    if (cur_v) begin
      check_eq("data_o", data_o, cur.d);
      check_eq("addr_o", 64'(addr_o), 64'(cur.a));
    end
    check_eq("stall_cnt_o", 64'(stall_cnt_o), STATS ? 64'(stall_m) : 64'd0);
    check_eq("bubble_cnt_o", 64'(bubble_cnt_o), STATS ? 64'(bub_m) : 64'd0);
  endtask

  // Drive one cycle of stimulus, let one edge pass, then update the
  // scoreboard and compare.
  task automatic step(input logic st, input logic fl, input logic v,
                      input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                      input logic [CTRL_W-1:0] c);
    stall_i = st; flush_i = fl; valid_i = v; data_i = d; addr_i = a; ctrl_i = c;
    if (!fl && !st && v) sb_q.push_back('{d: d, a: a, c: c, emit: sh + DEPTH});
    @(posedge clk);
    #2;
    if (fl) begin
      sb_q.delete();
      cur_v = 1'b0;
    end else if (st) begin
      if (stall_m != 16'hFFFF) stall_m++;
    end else begin
      if (!cur_v && bub_m != 16'hFFFF) bub_m++;
      sh++;
      cur_v = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].emit == sh) begin
        cur   = sb_q.pop_front();
        cur_v = 1'b1;
      end
    end
    check_outputs();
  endtask

  // Raise rst away from the clock edge. The outputs must clear without waiting for an edge.
  task automatic apply_reset();
    stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst valid_o", 64'(valid_o), 64'd0);
    check_eq("rst data_o", data_o, 64'd0);
    check_eq("rst addr_o", 64'(addr_o), 64'd0);
    check_eq("rst ctrl_o", 64'(ctrl_o), 64'd0);
    check_eq("rst busy_o", 64'(busy_o), 64'd0);
    check_eq("rst stall_cnt_o", 64'(stall_cnt_o), 64'd0);
    check_eq("rst bubble_cnt_o", 64'(bubble_cnt_o), 64'd0);
    sb_q.delete();
    cur_v = 1'b0; stall_m = '0; bub_m = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [15:0] s0;

  initial begin
    n_tests = 0; n_fail = 0; sh = 0; cur_v = 1'b0; stall_m = '0; bub_m = '0;
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    data_i = '0; addr_i = '0; ctrl_i = '0;
    #2;
    apply_reset();

    // Latency: A, B, C back-to-back, then drain with bubbles.
    step(0, 0, 1, 64'h1, 5'd1, 2'b01);
    step(0, 0, 1, 64'h2, 5'd2, 2'b10);
    step(0, 0, 1, 64'h3, 5'd3, 2'b11);
    check_eq("lat A not early", 64'(valid_o), 64'd1);
    check_eq("lat A data", data_o, 64'h1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 64'(i), 5'd7, 2'b11);

    // Stall: DEAD reaches the output and then holds for 4 stalled cycles while the inputs move.
    step(0, 0, 1, 64'hDEAD, 5'd5, 2'b11);
    step(0, 0, 0, 64'h0, 5'd0, 2'b11);
    step(0, 0, 0, 64'h0, 5'd0, 2'b11);
    s0 = stall_m;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 64'($urandom), 5'($urandom), 2'($urandom));
      check_eq("stall hold data", data_o, 64'hDEAD);
      check_eq("stall hold addr", 64'(addr_o), 64'd5);
      check_eq("stall hold ctrl", 64'(ctrl_o), 64'd3);
    end
    if (STATS) check_eq("stall_cnt +4", 64'(stall_cnt_o), 64'(s0 + 16'd4));

    // Flush together with stall: flush wins.
    step(1, 1, 1, 64'hBEEF, 5'd9, 2'b11);
    check_eq("flush addr_o", 64'(addr_o), 64'd0);
    check_eq("flush ctrl_o", 64'(ctrl_o), 64'd0);

    // Bubble gating: invalid inputs carrying ctrl=11.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 64'hF00D, 5'd31, 2'b11);

    // Reset mid-stream while slots are valid.
    step(0, 0, 1, 64'hA1, 5'd1, 2'b11);
    step(0, 0, 1, 64'hA2, 5'd2, 2'b11);
    step(0, 0, 1, 64'hA3, 5'd3, 2'b11);
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 64'h0, 5'd0, 2'b00);

    // Random mix of stall, flush, valid and bubble.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 9) < 7), {32'($urandom), 32'($urandom)},
           5'($urandom), 2'($urandom));
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    // Saturation of the stall counter.
    for (int i = 0; i < 70000; i++) step(1, 0, 0, 64'h0, 5'd0, 2'b00);
    check_eq("stall_cnt sat", 64'(stall_cnt_o), 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
